// File: rtl/game_pkg.sv
// Shared game constants and the timer state encoding; also imported by the score block.
package game_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_STOPPED = 2'd3
   } game_state_e;

   localparam int TIMER_W          = 11;
   localparam int TIME_LIMIT       = 600;
   localparam int TIMER_MAX        = 2047;
   localparam int CLK_FREQ_DEFAULT = 50000000;

endpackage

// File: rtl/game_timer_bcd_digit_counter.sv
// One BCD display digit counting modulo MODULUS; registered digit, combinational carry.
// Latency: digit updates on the edge after inc; no backpressure (inc is a single-cycle strobe).
module bcd_digit_counter #(
   parameter int MODULUS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc,
   output logic [3:0] digit,
   output logic       carry
);

   logic [3:0] digit_q;
   logic [3:0] digit_d;
   logic       at_top;

   assign at_top = (digit_q == 4'(MODULUS - 1));
   // The carry feeds the next digit's inc on the same edge, so it cannot be registered.
   assign carry  = inc && at_top;
   assign digit  = digit_q;

   always_comb begin
      digit_d = digit_q;
      if (clear) begin
         digit_d = 4'd0;
      end else if (inc) begin
         digit_d = at_top ? 4'd0 : digit_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_q <= 4'd0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

// File: rtl/game_timer.sv
// Game elapsed-seconds timer: prescaler, control FSM, saturating binary count and mm:ss BCD digits.
// Latency: all outputs registered, one edge after the controlling pulse; no backpressure.
module game_timer #(
   parameter int CLK_FREQ = game_pkg::CLK_FREQ_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        resume,
   input  logic        stop,
   output logic [10:0] timer,
   output logic [3:0]  sec_ones,
   output logic [3:0]  sec_tens,
   output logic [3:0]  min_ones,
   output logic [3:0]  min_tens,
   output logic        running,
   output logic        second_tick,
   output logic        time_up
);

   import game_pkg::*;

   localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0]      PRESC_LAST = PW'(CLK_FREQ - 1);
   localparam logic [TIMER_W-1:0] T_MAX      = TIMER_W'(TIMER_MAX);
   localparam logic [TIMER_W-1:0] T_PRE_UP   = TIMER_W'(TIME_LIMIT - 1);

   game_state_e        state_q, state_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               running_q, running_d;
   logic               second_tick_q, second_tick_d;
   logic               time_up_q, time_up_d;
   logic               digit_clear;
   logic               digit_inc;
   logic               c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;

   always_comb begin
      state_d       = state_q;
      presc_d       = presc_q;
      timer_d       = timer_q;
      second_tick_d = 1'b0;
      time_up_d     = 1'b0;
      digit_clear   = 1'b0;
      digit_inc     = 1'b0;

      if (start) begin
         state_d     = ST_RUNNING;
         presc_d     = '0;
         timer_d     = '0;
         digit_clear = 1'b1;
      end else if (stop && (state_q == ST_RUNNING || state_q == ST_PAUSED)) begin
         state_d = ST_STOPPED;
      end else begin
         case (state_q)
            ST_RUNNING: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (presc_q == PRESC_LAST) begin
                  presc_d = '0;
                  // Saturated: the prescaler keeps cycling but the second is not counted.
                  if (timer_q != T_MAX) begin
                     timer_d       = timer_q + 1'b1;
                     digit_inc     = 1'b1;
                     second_tick_d = 1'b1;
                     time_up_d     = (timer_q == T_PRE_UP);
                  end
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            ST_PAUSED: begin
               if (resume) begin
                  state_d = ST_RUNNING;
               end
            end
            default: ;
         endcase
      end

      running_d = (state_d == ST_RUNNING);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         presc_q       <= '0;
         timer_q       <= '0;
         running_q     <= 1'b0;
         second_tick_q <= 1'b0;
         time_up_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         timer_q       <= timer_d;
         running_q     <= running_d;
         second_tick_q <= second_tick_d;
         time_up_q     <= time_up_d;
      end
   end

   bcd_digit_counter #(.MODULUS(10)) u_sec_ones (
      .clk   (clk),
      .reset (reset),
      .clear (digit_clear),
      .inc   (digit_inc),
      .digit (sec_ones),
      .carry (c_sec_ones)
   );

   bcd_digit_counter #(.MODULUS(6)) u_sec_tens (
      .clk   (clk),
      .reset (reset),
      .clear (digit_clear),
      .inc   (c_sec_ones),
      .digit (sec_tens),
      .carry (c_sec_tens)
   );

   bcd_digit_counter #(.MODULUS(10)) u_min_ones (
      .clk   (clk),
      .reset (reset),
      .clear (digit_clear),
      .inc   (c_sec_tens),
      .digit (min_ones),
      .carry (c_min_ones)
   );

   // Minutes tens never wraps in practice: the count saturates at 34:07.
   bcd_digit_counter #(.MODULUS(4)) u_min_tens (
      .clk   (clk),
      .reset (reset),
      .clear (digit_clear),
      .inc   (c_min_ones),
      .digit (min_tens),
      .carry (c_min_tens)
   );

   assign timer       = timer_q;
   assign running     = running_q;
   assign second_tick = second_tick_q;
   assign time_up     = time_up_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed plus randomized bench for game_timer against an elapsed-cycle reference model.
module tb_game_timer;

   localparam int F = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STOP = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0, pause = 1'b0, resume = 1'b0, stop = 1'b0;
   logic [10:0] timer;
   logic [3:0]  sec_ones, sec_tens, min_ones, min_tens;
   logic        running, second_tick, time_up;

   always #5 clk = ~clk;

   game_timer #(.CLK_FREQ(F)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .pause       (pause),
      .resume      (resume),
      .stop        (stop),
      .timer       (timer),
      .sec_ones    (sec_ones),
      .sec_tens    (sec_tens),
      .min_ones    (min_ones),
      .min_tens    (min_tens),
      .running     (running),
      .second_tick (second_tick),
      .time_up     (time_up)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: total cycles spent running since start; seconds derive from it.
   int m_mode = M_IDLE;
   int m_rc   = 0;
   int m_secs = 0;
   bit m_tick = 0;
   bit m_tup  = 0;

   function automatic logic [31:0] expected_vec();
      int mm = m_secs / 60;
      int ss = m_secs % 60;
      logic [31:0] v;
      v = {2'b00, 11'(m_secs), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
           (m_mode == M_RUN), m_tick, m_tup};
      return v;
   endfunction

   function automatic logic [31:0] observed_vec();
      return {2'b00, timer, min_tens, min_ones, sec_tens, sec_ones, running, second_tick, time_up};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit s, input bit t, input bit p, input bit r);
      int nsecs;
      m_tick = 0;
      m_tup  = 0;
      if (s) begin
         m_mode = M_RUN; m_rc = 0; m_secs = 0;
      end else if (t && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
         m_mode = M_STOP;
      end else if (m_mode == M_RUN && p) begin
         m_mode = M_PAUSE;
      end else if (m_mode == M_PAUSE && r) begin
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         m_rc++;
         nsecs = (m_rc / F > 2047) ? 2047 : m_rc / F;
         if (nsecs != m_secs) begin
            m_tick = 1;
            if (nsecs == 600) m_tup = 1;
         end
         m_secs = nsecs;
      end
   endtask

   task automatic cyc(input bit s, input bit t, input bit p, input bit r);
      @(negedge clk);
      start = s; stop = t; pause = p; resume = r;
      model_step(s, t, p, r);
      @(posedge clk);
      #1;
      chk("cycle", observed_vec(), expected_vec());
      start = 0; stop = 0; pause = 0; resume = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      m_mode = M_IDLE; m_rc = 0; m_secs = 0; m_tick = 0; m_tup = 0;
      chk("reset", observed_vec(), 32'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_until(input int target);
      int g = 0;
      while (m_secs < target && g < 20000) begin
         cyc(0, 0, 0, 0);
         g++;
      end
      chk("reach", 32'(timer), 32'(target));
   endtask

   initial begin
      int t0, cnt, g, rnd;

      #3;
      do_reset();

      // Basic counting: 16 cycles -> 4 seconds
      cyc(1, 0, 0, 0);
      chk("start_zero", 32'(timer), 32'd0);
      for (int i = 0; i < 16; i++) cyc(0, 0, 0, 0);
      chk("t16_timer", 32'(timer), 32'd4);
      chk("t16_ones", 32'(sec_ones), 32'd4);

      // Minute rollover
      run_until(59);
      run_until(60);
      chk("min_roll", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0000_0100);

      // Pause two cycles into a second
      g = 0;
      while (!m_tick && g < 10) begin cyc(0, 0, 0, 0); g++; end
      chk("tick_seen", 32'(second_tick), 32'd1);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      t0 = int'(timer);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0);
      chk("pause_hold", 32'(timer), 32'(t0));
      chk("pause_run0", 32'(running), 32'd0);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      chk("resume_notick", 32'(second_tick), 32'd0);
      cyc(0, 0, 0, 0);
      chk("resume_tick", {second_tick, 20'd0, timer}, {1'b1, 20'd0, 11'(t0 + 1)});

      // time_up once at 10:00
      run_until(599);
      cnt = 0;
      g = 0;
      while (m_secs < 605 && g < 100) begin
         cyc(0, 0, 0, 0);
         if (time_up) begin
            cnt++;
            chk("time_up_at", 32'(timer), 32'd600);
         end
         g++;
      end
      chk("time_up_once", 32'(cnt), 32'd1);

      // Saturation at 34:07
      run_until(2047);
      chk("sat_digits", {16'd0, min_tens, min_ones, sec_tens, sec_ones}, 32'h0000_3407);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, 0);
         if (second_tick) cnt++;
      end
      chk("sat_notick", 32'(cnt), 32'd0);
      chk("sat_hold", {running, 20'd0, timer}, {1'b1, 20'd0, 11'd2047});

      // Randomized control pulses
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         rnd = int'($urandom_range(0, 199));
         cyc(rnd < 2, rnd == 2, rnd >= 3 && rnd < 8, rnd >= 8 && rnd < 14);
      end

      // start beats stop; stopped state ignores pause/resume; async reset
      cyc(1, 0, 0, 0);
      run_until(37);
      cyc(1, 1, 0, 0);
      chk("start_wins", {running, 20'd0, timer}, {1'b1, 20'd0, 11'd0});
      for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      t0 = int'(timer);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
      chk("stopped_hold", {running, 20'd0, timer}, {1'b0, 20'd0, 11'(t0)});
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
      @(negedge clk);
      #2;
      do_reset();
      cyc(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
